// File: rtl/tx_unit.sv
// tx_unit: serial transmitter. Latches the frame format on Send, then sends start, data LSB first, optional parity and stop bits.
// Build option: define TX_UNIT_PARITY_EN to enable the parity bit and the PARITY state.
module tx_unit (
   input  logic       clock,
   input  logic       ResetN,
   input  logic       Send,
   input  logic [7:0] DataIn,
   input  logic       DataLength,
   input  logic       StopBits,
   input  logic [1:0] ParityType,
   input  logic [1:0] BaudRate,
   output logic       DataOut,
   output logic       ParallParOut,
   output logic       ActiveFlag,
   output logic       DoneFlag
);

   localparam int unsigned CNT_W  = 15;
   localparam int unsigned IDX_W  = 3;
   localparam int unsigned DATA_W = 8;

`ifdef TX_UNIT_PARITY_EN
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;
`else
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd4
   } state_t;
`endif

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic                len_q, len_d;
   logic                stop_q, stop_d;
   logic [1:0]          baud_q, baud_d;
   logic                out_q, out_d;
   logic                active_q, active_d;
   logic                done_q, done_d;

   logic [CNT_W-1:0]    last_cnt;
   logic [IDX_W-1:0]    last_idx;
   logic [DATA_W-1:0]   data_sel;
   logic                bit_end;

`ifdef TX_UNIT_PARITY_EN
   logic                par_q, par_d;
   logic                par_en_q, par_en_d;
`else
   logic                unused_parity_type;
   assign unused_parity_type = ^ParityType;
`endif

   // Bit period in clocks minus one, from the latched baud select
   always_comb begin
      last_cnt = CNT_W'(2603);
      case (baud_q)
         2'b00:   last_cnt = CNT_W'(20832);
         2'b01:   last_cnt = CNT_W'(10416);
         2'b10:   last_cnt = CNT_W'(5207);
         default: last_cnt = CNT_W'(2603);
      endcase
   end

   assign bit_end  = (cnt_q == last_cnt);
   assign last_idx = len_q ? IDX_W'(7) : IDX_W'(6);
   assign data_sel = DataLength ? DataIn : {1'b0, DataIn[6:0]};

   // Next-state, counters and next values of the registered outputs
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      data_d   = data_q;
      len_d    = len_q;
      stop_d   = stop_q;
      baud_d   = baud_q;
      done_d   = 1'b0;
      out_d    = 1'b1;
      active_d = 1'b0;
`ifdef TX_UNIT_PARITY_EN
      par_d    = par_q;
      par_en_d = par_en_q;
`endif

      if (state_q != IDLE) begin
         cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
      end

      case (state_q)
         IDLE: begin
            if (Send) begin
               state_d = START;
               cnt_d   = '0;
               idx_d   = '0;
               data_d  = data_sel;
               len_d   = DataLength;
               stop_d  = StopBits;
               baud_d  = BaudRate;
`ifdef TX_UNIT_PARITY_EN
               par_en_d = ParityType[1] ^ ParityType[0];
               case (ParityType)
                  2'b01:   par_d = ~^data_sel;
                  2'b10:   par_d = ^data_sel;
                  default: par_d = 1'b0;
               endcase
`endif
            end
         end
         START: begin
            if (bit_end) begin
               state_d = DATA;
               idx_d   = '0;
            end
         end
         DATA: begin
            if (bit_end) begin
               if (idx_q == last_idx) begin
                  idx_d = '0;
`ifdef TX_UNIT_PARITY_EN
                  state_d = par_en_q ? PARITY : STOP;
`else
                  state_d = STOP;
`endif
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
`ifdef TX_UNIT_PARITY_EN
         PARITY: begin
            if (bit_end) begin
               state_d = STOP;
               idx_d   = '0;
            end
         end
`endif
         STOP: begin
            if (bit_end) begin
               if (idx_q == IDX_W'(stop_q)) begin
                  state_d = IDLE;
                  idx_d   = '0;
                  done_d  = 1'b1;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            idx_d   = '0;
         end
      endcase

      // Line level follows the state being entered so DataOut is registered
      active_d = (state_d != IDLE);
      case (state_d)
         START:   out_d = 1'b0;
         DATA:    out_d = data_d[idx_d];
`ifdef TX_UNIT_PARITY_EN
         PARITY:  out_d = par_d;
`endif
         default: out_d = 1'b1;
      endcase
   end

   always_ff @(posedge clock) begin
      if (ResetN) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         idx_q    <= '0;
         data_q   <= '0;
         len_q    <= 1'b0;
         stop_q   <= 1'b0;
         baud_q   <= '0;
         out_q    <= 1'b1;
         active_q <= 1'b0;
         done_q   <= 1'b0;
`ifdef TX_UNIT_PARITY_EN
         par_q    <= 1'b0;
         par_en_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         data_q   <= data_d;
         len_q    <= len_d;
         stop_q   <= stop_d;
         baud_q   <= baud_d;
         out_q    <= out_d;
         active_q <= active_d;
         done_q   <= done_d;
`ifdef TX_UNIT_PARITY_EN
         par_q    <= par_d;
         par_en_q <= par_en_d;
`endif
      end
   end

   assign DataOut    = out_q;
   assign ActiveFlag = active_q;
   assign DoneFlag   = done_q;
`ifdef TX_UNIT_PARITY_EN
   assign ParallParOut = par_q;
`else
   assign ParallParOut = 1'b0;
`endif

endmodule

// File: tb/tb_tx_unit.sv
// tb_tx_unit: directed self-checking bench for tx_unit; expectations follow TX_UNIT_PARITY_EN.
module tb_tx_unit;

   localparam int unsigned N11 = 2604;
`ifdef TX_UNIT_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   logic       clock = 1'b0;
   logic       ResetN;
   logic       Send;
   logic [7:0] DataIn;
   logic       DataLength;
   logic       StopBits;
   logic [1:0] ParityType;
   logic [1:0] BaudRate;
   logic       DataOut;
   logic       ParallParOut;
   logic       ActiveFlag;
   logic       DoneFlag;

   int checks = 0;
   int errors = 0;

   always #10 clock = ~clock;

   tx_unit dut (
      .clock       (clock),
      .ResetN      (ResetN),
      .Send        (Send),
      .DataIn      (DataIn),
      .DataLength  (DataLength),
      .StopBits    (StopBits),
      .ParityType  (ParityType),
      .BaudRate    (BaudRate),
      .DataOut     (DataOut),
      .ParallParOut(ParallParOut),
      .ActiveFlag  (ActiveFlag),
      .DoneFlag    (DoneFlag)
   );

   task automatic tick(input int n);
      repeat (n) @(negedge clock);
   endtask

   // Called on the negedge where Send was raised; cycle 0 is the negedge after the start edge.
   task automatic capture_frame(input int nbits, input int per,
                                output logic [11:0] fo, output logic [11:0] lo,
                                output int early_done, output logic [2:0] end_flags,
                                output logic act_ok);
      fo = '0;
      lo = '0;
      early_done = 0;
      act_ok = 1'b1;
      for (int c = 0; c < nbits * per; c++) begin
         @(negedge clock);
         if (c % per == 0)       fo[c / per] = DataOut;
         if (c % per == per - 1) lo[c / per] = DataOut;
         if (DoneFlag === 1'b1)   early_done++;
         if (ActiveFlag !== 1'b1) act_ok = 1'b0;
      end
      @(negedge clock);
      end_flags = {DoneFlag, ActiveFlag, DataOut};
   endtask

   task automatic test_reset;
      ResetN = 1'b1; Send = 1'b1;
      DataIn = 8'hAA; DataLength = 1'b1; StopBits = 1'b0; ParityType = 2'b01; BaudRate = 2'b11;
      tick(3);
      checks++; if (DataOut !== 1'b1) begin errors++; $display("FAIL reset_dataout got %b exp 1", DataOut); end
      checks++; if (ActiveFlag !== 1'b0) begin errors++; $display("FAIL reset_active got %b exp 0", ActiveFlag); end
      checks++; if (DoneFlag !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", DoneFlag); end
      checks++; if (ParallParOut !== 1'b0) begin errors++; $display("FAIL reset_parity got %b exp 0", ParallParOut); end
      ResetN = 1'b0; Send = 1'b0;
      tick(3);
      checks++; if (DataOut !== 1'b1) begin errors++; $display("FAIL idle_dataout got %b exp 1", DataOut); end
      checks++; if (ActiveFlag !== 1'b0) begin errors++; $display("FAIL idle_active got %b exp 0", ActiveFlag); end
   endtask

   // 0xAA, 7 bits, even parity, 2 stops; Send drops and inputs change one clock into the frame
   task automatic test_parity_frame;
      logic [11:0] fo, lo, exp_v, mask;
      int ed, nb;
      logic [2:0] ef;
      logic ao;
      nb    = PAR_EN ? 11 : 10;
      exp_v = PAR_EN ? 12'h754 : 12'h354;
      mask  = PAR_EN ? 12'h7FF : 12'h3FF;
      DataIn = 8'hAA; DataLength = 1'b0; StopBits = 1'b1; ParityType = 2'b10; BaudRate = 2'b11;
      Send = 1'b1;
      fork
         capture_frame(nb, N11, fo, lo, ed, ef, ao);
         begin
            tick(2);
            Send = 1'b0; DataIn = 8'h55; DataLength = 1'b1; StopBits = 1'b0;
            ParityType = 2'b01; BaudRate = 2'b00;
         end
      join
      checks++; if ((fo & mask) !== exp_v) begin errors++; $display("FAIL par_bits_first got %h exp %h", fo & mask, exp_v); end
      checks++; if ((lo & mask) !== exp_v) begin errors++; $display("FAIL par_bits_last got %h exp %h", lo & mask, exp_v); end
      checks++; if (ed !== 0) begin errors++; $display("FAIL par_early_done got %0d exp 0", ed); end
      checks++; if (ef !== 3'b101) begin errors++; $display("FAIL par_end_flags got %b exp 101", ef); end
      checks++; if (ao !== 1'b1) begin errors++; $display("FAIL par_active got %b exp 1", ao); end
      checks++; if (ParallParOut !== PAR_EN) begin errors++; $display("FAIL par_out got %b exp %b", ParallParOut, PAR_EN); end
      tick(1);
      checks++; if ({DoneFlag, ActiveFlag, DataOut} !== 3'b001) begin
         errors++; $display("FAIL par_after_done got %b exp 001", {DoneFlag, ActiveFlag, DataOut}); end
   endtask

   // 0xAA 7N2 with Send held; a second 8O1 frame must start on the clock after DoneFlag
   task automatic test_back_to_back;
      logic [11:0] fo, lo;
      int ed;
      logic [2:0] ef;
      logic ao;
      DataIn = 8'hAA; DataLength = 1'b0; StopBits = 1'b1; ParityType = 2'b11; BaudRate = 2'b11;
      Send = 1'b1;
      fork
         capture_frame(10, N11, fo, lo, ed, ef, ao);
         begin
            tick(2);
            DataLength = 1'b1; StopBits = 1'b0; ParityType = 2'b01;
         end
      join
      checks++; if ((fo & 12'h3FF) !== 12'h354) begin errors++; $display("FAIL b2b_bits_first got %h exp 354", fo & 12'h3FF); end
      checks++; if ((lo & 12'h3FF) !== 12'h354) begin errors++; $display("FAIL b2b_bits_last got %h exp 354", lo & 12'h3FF); end
      checks++; if (ed !== 0) begin errors++; $display("FAIL b2b_early_done got %0d exp 0", ed); end
      checks++; if (ef !== 3'b101) begin errors++; $display("FAIL b2b_end_flags got %b exp 101", ef); end
      checks++; if (ao !== 1'b1) begin errors++; $display("FAIL b2b_active got %b exp 1", ao); end
      checks++; if (ParallParOut !== 1'b0) begin errors++; $display("FAIL b2b_par_none got %b exp 0", ParallParOut); end
      tick(1);
      checks++; if ({DoneFlag, ActiveFlag, DataOut} !== 3'b010) begin
         errors++; $display("FAIL b2b_restart got %b exp 010", {DoneFlag, ActiveFlag, DataOut}); end
      checks++; if (ParallParOut !== PAR_EN) begin errors++; $display("FAIL b2b_par_odd got %b exp %b", ParallParOut, PAR_EN); end
      tick(2 * N11 - 1);
      checks++; if (DataOut !== 1'b0) begin errors++; $display("FAIL b2b_data0 got %b exp 0", DataOut); end
      tick(1);
      checks++; if (DataOut !== 1'b1) begin errors++; $display("FAIL b2b_data1 got %b exp 1", DataOut); end
   endtask

   // Reset in the middle of the data bits of the frame left running above
   task automatic test_reset_abort;
      int bad;
      tick(N11 / 2);
      ResetN = 1'b1; Send = 1'b0;
      tick(1);
      checks++; if ({DoneFlag, ActiveFlag, DataOut} !== 3'b001) begin
         errors++; $display("FAIL abort_flags got %b exp 001", {DoneFlag, ActiveFlag, DataOut}); end
      checks++; if (ParallParOut !== 1'b0) begin errors++; $display("FAIL abort_parity got %b exp 0", ParallParOut); end
      ResetN = 1'b0;
      bad = 0;
      for (int i = 0; i < 40; i++) begin
         tick(1);
         if (DoneFlag !== 1'b0 || ActiveFlag !== 1'b0 || DataOut !== 1'b1) bad++;
      end
      checks++; if (bad !== 0) begin errors++; $display("FAIL abort_idle got %0d bad cycles exp 0", bad); end
   endtask

   // Start-bit length for the 9600 and 2400 divisors, using 0xFF so data bit 0 is high
   task automatic test_baud_rates;
      logic [1:0] rate;
      int per;
      for (int i = 0; i < 2; i++) begin
         rate = (i == 0) ? 2'b10 : 2'b00;
         per  = (i == 0) ? 5208 : 20833;
         DataIn = 8'hFF; DataLength = 1'b1; StopBits = 1'b0; ParityType = 2'b00; BaudRate = rate;
         Send = 1'b1;
         tick(1);
         Send = 1'b0; BaudRate = 2'b11;
         tick(per - 1);
         checks++; if (DataOut !== 1'b0) begin errors++; $display("FAIL baud%0d_start_end got %b exp 0", i, DataOut); end
         tick(1);
         checks++; if (DataOut !== 1'b1) begin errors++; $display("FAIL baud%0d_data0 got %b exp 1", i, DataOut); end
         ResetN = 1'b1;
         tick(1);
         ResetN = 1'b0;
         tick(2);
      end
   endtask

   initial begin
      test_reset();
      test_parity_frame();
      test_back_to_back();
      test_reset_abort();
      test_baud_rates();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/tx_unit.md
TX_UNIT -- requirements
Module: tx_unit

Interface
REQ-001 SHALL have port clock, input, 1 bit: single system clock, 50 MHz, all logic on rising edge.
REQ-002 SHALL have port ResetN, input, 1 bit: synchronous, active-high reset; the name is kept for compatibility and does not imply low polarity.
REQ-003 SHALL have port Send, input, 1 bit: level request to transmit.
REQ-004 SHALL have port DataIn, input, 8 bits: data word, sent LSB first.
REQ-005 SHALL have port DataLength, input, 1 bit: 1 selects 8 data bits; 0 selects 7 data bits, DataIn[6:0].
REQ-006 SHALL have port StopBits, input, 1 bit: 0 selects 1 stop bit; 1 selects 2 stop bits.
REQ-007 SHALL have port ParityType, input, 2 bits: 00 none, 01 odd, 10 even, 11 none.
REQ-008 SHALL have port BaudRate, input, 2 bits: 00 2400, 01 4800, 10 9600, 11 19200 baud.
REQ-009 SHALL have port DataOut, output, 1 bit: serial line, idle high.
REQ-010 SHALL have port ParallParOut, output, 1 bit: parity bit computed for the latched frame.
REQ-011 SHALL have port ActiveFlag, output, 1 bit: high while a frame is on the line.
REQ-012 SHALL have port DoneFlag, output, 1 bit: one-cycle pulse at frame completion.

Function
REQ-013 SHALL hold each bit for exactly N clocks, with N = 20833 / 10417 / 5208 / 2604 for BaudRate 00 / 01 / 10 / 11. The bit counter restarts at frame start.
REQ-014 SHALL send frames in the order: start bit (0), data bits LSB first (7 or 8), optional parity bit, then stop bits (1 or 2, value 1).
REQ-015 SHALL use a state machine with states IDLE, START, DATA, PARITY, STOP. Transitions are IDLE->START->DATA->(PARITY if enabled)->STOP->IDLE.
REQ-016 SHALL, in IDLE with Send=1 at a rising edge, latch DataIn, DataLength, StopBits, ParityType and BaudRate, drive DataOut=0 and set ActiveFlag=1, all registered from that edge.
REQ-017 SHALL ignore input changes mid-frame; only the latched values are used.
REQ-018 SHALL compute parity over the transmitted data bits only: odd gives a total count of ones that is odd, even gives a count that is even. ParallParOut is updated at latch time and held until the next latch.
REQ-019 SHALL, at the end of the last stop-bit period, return to IDLE, drop ActiveFlag, and pulse DoneFlag=1 for exactly one clock.
REQ-020 SHALL, if Send is still 1 on the cycle after DoneFlag, start a new frame immediately (back-to-back). If Send is 0, stay in IDLE with DataOut=1.
REQ-021 SHALL treat Send=0 mid-frame as no effect; the frame completes.
REQ-022 SHALL hold DataOut=1, ActiveFlag=0 and DoneFlag=0 continuously in IDLE.

Reset
REQ-023 SHALL, while ResetN=1 at a rising edge, set state IDLE and clear all counters, giving DataOut=1, ActiveFlag=0, DoneFlag=0, ParallParOut=0.
REQ-024 SHALL abort a frame when reset is asserted mid-frame, with no DoneFlag pulse. After release it waits in IDLE for Send.
REQ-025 SHALL give reset priority over Send when both are asserted.

Configuration
REQ-026 SHALL support macro TX_UNIT_PARITY_EN. When defined, parity operates per REQ-007/REQ-018.
REQ-027 SHALL, when TX_UNIT_PARITY_EN is undefined, ignore ParityType, never send a parity bit, omit the PARITY state, and tie ParallParOut to 0.

Verification
REQ-028 SHALL cover: DataIn=0xAA, 8 bits, parity 00, 1 stop, BaudRate 00 -> DataOut 0,0,1,0,1,0,1,0,1,1, each bit 20833 clocks; DoneFlag pulses at 208330 clocks.
REQ-029 SHALL cover: 0xAA, 8 bits, odd parity, 1 stop, BaudRate 01 -> parity bit 1 (ParallParOut=1), 11 bits of 10417 clocks each.
REQ-030 SHALL cover: 0xAA, 7 bits, even parity, 2 stop, BaudRate 10 -> data 0,1,0,1,0,1,0, parity 1, stops 1,1, each bit 5208 clocks.
REQ-031 SHALL cover: 0xAA, 7 bits, ParityType 11, 2 stop, BaudRate 11 -> no parity bit, 10 bits of 2604 clocks; with Send held, a second frame starts on the clock after DoneFlag.
REQ-032 SHALL cover: ResetN=1 asserted during the data bits -> next edge DataOut=1, ActiveFlag=0, no DoneFlag.
REQ-033 SHALL cover: Send toggled 1->0 one clock after frame start -> the full frame is still sent and DoneFlag pulses once.
